// File: rtl/cpu19_pkg.sv
// rtl/cpu19_pkg.sv - shared opcodes, field positions, widths and ALU op encoding for cpu19
// Purpose : common definitions imported by cpu19_alu and cpu19_core.
// Contents: DATA_W/PC_W defaults, opcode constants, instruction field bit
//           positions, ALU-operation enum and an opcode-to-ALU-op helper.
package cpu19_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int PC_W_DEF   = 32;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_NOR   = 4'h5;
   localparam logic [3:0] OP_SLL   = 4'h6;
   localparam logic [3:0] OP_SRL   = 4'h7;
   localparam logic [3:0] OP_LOADI = 4'h8;
   localparam logic [3:0] OP_BRANZ = 4'h9;
   localparam logic [3:0] OP_BRAZ  = 4'hA;
   localparam logic [3:0] OP_JUMP  = 4'hB;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam int OP_MSB = 18;
   localparam int OP_LSB = 15;
   localparam int A_MSB  = 14;
   localparam int A_LSB  = 10;
   localparam int B_MSB  = 9;
   localparam int B_LSB  = 5;
   localparam int C_MSB  = 4;
   localparam int C_LSB  = 0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOR = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_t;

   // Register-register opcodes map one-to-one onto the ALU encoding; every
   // other opcode runs a subtract so branches can use its zero detect.
   function automatic alu_op_t alu_op_of(input logic [3:0] op);
      if (op[3] == 1'b0) return alu_op_t'(op[2:0]);
      return ALU_SUB;
   endfunction

endpackage

// File: rtl/cpu19_alu.sv
// rtl/cpu19_alu.sv - combinational ALU for cpu19, shared by arithmetic and branch compare
// Purpose : computes result = a <op> b and flags a zero result.
// Ports   : op     - ALU operation (alu_op_t encoding)
//           a, b   - operands, DATA_W bits
//           result - DATA_W-bit result, modulo 2^DATA_W
//           zero   - high when result is all zeros
module cpu19_alu
   import cpu19_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   alu_op_t op_e;
   assign op_e = alu_op_t'(op);

   always_comb begin
      result = '0;
      case (op_e)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         // Only the low three bits of the shift operand count.
         ALU_SLL: result = a << b[2:0];
         ALU_SRL: result = a >> b[2:0];
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/cpu19_core.sv
// rtl/cpu19_core.sv - single-cycle 19-bit-instruction register CPU core
// Purpose : fetches INSTRUCTION at PC, executes it and updates the register
//           file and PC at the same rising edge (one instruction per cycle).
// Ports   : CLK         - clock, all state changes on the rising edge
//           RESET       - synchronous active-low reset (PC and registers to 0)
//           PC          - word address of the current instruction
//           INSTRUCTION - instruction at PC, consumed combinationally
//           HALTED      - high while halted (only with CPU19_HALT_EN defined)
// Option  : `define CPU19_HALT_EN makes opcode 1111 a sticky HALT.
module cpu19_core
   import cpu19_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF
) (
   input  logic            CLK,
   input  logic            RESET,
   output logic [PC_W-1:0] PC,
   input  logic [18:0]     INSTRUCTION
`ifdef CPU19_HALT_EN
   ,
   output logic            HALTED
`endif
);

   logic [3:0]        op;
   logic [4:0]        fa, fb, fc;
   logic [DATA_W-1:0] regs [32];
   logic [DATA_W-1:0] rd_a, rd_b, rd_c;
   logic [DATA_W-1:0] alu_x, alu_y, alu_res;
   logic              alu_zero;
   logic              is_branch, taken, we, stall;
   logic [DATA_W-1:0] wdata;
   logic [PC_W-1:0]   pc_next;

   assign op = INSTRUCTION[OP_MSB:OP_LSB];
   assign fa = INSTRUCTION[A_MSB:A_LSB];
   assign fb = INSTRUCTION[B_MSB:B_LSB];
   assign fc = INSTRUCTION[C_MSB:C_LSB];

   // R0 is forced to zero on read so it never depends on stored contents.
   assign rd_a = (fa == 5'd0) ? '0 : regs[fa];
   assign rd_b = (fb == 5'd0) ? '0 : regs[fb];
   assign rd_c = (fc == 5'd0) ? '0 : regs[fc];

   // Branches compare R[a] against R[b]; everything else operates on R[b], R[c].
   assign is_branch = (op == OP_BRANZ) || (op == OP_BRAZ);
   assign alu_x     = is_branch ? rd_a : rd_b;
   assign alu_y     = is_branch ? rd_b : rd_c;

   cpu19_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op_of(op)),
      .a      (alu_x),
      .b      (alu_y),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Opcode is decoded first so a JUMP never looks at the (don't-care) compare.
   always_comb begin
      taken = 1'b0;
      case (op)
         OP_JUMP:  taken = 1'b1;
         OP_BRANZ: taken = ~alu_zero;
         OP_BRAZ:  taken = alu_zero;
         default:  taken = 1'b0;
      endcase
   end

   assign we      = (op[3] == 1'b0) || (op == OP_LOADI);
   assign wdata   = (op == OP_LOADI) ? DATA_W'(fc) : alu_res;
   assign pc_next = taken ? PC_W'(fc) : PC + PC_W'(1);

`ifdef CPU19_HALT_EN
   logic halted;

   // The HALT instruction itself already freezes PC and writes.
   assign stall  = halted || (op == OP_HALT);
   assign HALTED = halted;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         halted <= 1'b0;
      end else if (op == OP_HALT) begin
         halted <= 1'b1;
      end
   end
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         PC <= '0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (!stall) begin
         PC <= pc_next;
         if (we && (fa != 5'd0)) begin
            regs[fa] <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu19_core.sv
// tb/tb_cpu19_core.sv - self-checking bench for cpu19_core with a scoreboard of expected PC/writeback
module tb_cpu19_core;

   logic        CLK;
   logic        RESET;
   logic [31:0] PC;
   logic [18:0] INSTRUCTION;
`ifdef CPU19_HALT_EN
   logic        halted;
`endif

   logic [18:0] imem [32];
   logic [7:0]  m_r [32];
   logic [31:0] m_pc;
   int          tests;
   int          fails;

   typedef struct {
      logic [31:0] pc;
      bit          chk;
      int          idx;
      logic [7:0]  val;
      string       tag;
   } exp_t;

   exp_t sb [$];

   cpu19_core dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PC          (PC),
      .INSTRUCTION (INSTRUCTION)
`ifdef CPU19_HALT_EN
      ,
      .HALTED      (halted)
`endif
   );

   assign INSTRUCTION = imem[PC[4:0]];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [18:0] enc(input logic [3:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c);
      return {op, a, b, c};
   endfunction

   function automatic logic [7:0] rv(input logic [4:0] i);
      return (i == 5'd0) ? 8'h00 : m_r[i];
   endfunction

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      tests++;
      assert (PC === e.pc) else begin
         fails++;
         $error("FAIL %s_pc got %0h expected %0h", e.tag, PC, e.pc);
      end
      if (e.chk) chk8({e.tag, "_wb"}, dut.regs[e.idx], e.val);
   endtask

   // Predict the effect of the instruction at the model PC, queue it, clock once, compare.
   task automatic step(input string tag);
      logic [18:0] ins;
      logic [3:0]  op;
      logic [4:0]  a, b, c;
      logic [7:0]  x, y, v;
      logic [31:0] npc;
      bit          wr;
      exp_t        e;
      ins = imem[m_pc[4:0]];
      op  = ins[18:15];
      a   = ins[14:10];
      b   = ins[9:5];
      c   = ins[4:0];
      x   = rv(b);
      y   = rv(c);
      v   = 8'h00;
      wr  = 1'b0;
      npc = m_pc + 32'd1;
      case (op)
         4'h0: begin v = x + y;       wr = 1'b1; end
         4'h1: begin v = x - y;       wr = 1'b1; end
         4'h2: begin v = x & y;       wr = 1'b1; end
         4'h3: begin v = x | y;       wr = 1'b1; end
         4'h4: begin v = x ^ y;       wr = 1'b1; end
         4'h5: begin v = ~(x | y);    wr = 1'b1; end
         4'h6: begin v = x << y[2:0]; wr = 1'b1; end
         4'h7: begin v = x >> y[2:0]; wr = 1'b1; end
         4'h8: begin v = {3'b000, c}; wr = 1'b1; end
         4'h9: if (rv(a) != x) npc = {27'd0, c};
         4'hA: if (rv(a) == x) npc = {27'd0, c};
         4'hB: npc = {27'd0, c};
         default: ;
      endcase
      e.pc  = npc;
      e.chk = wr;
      e.idx = wr ? int'(a) : 0;
      e.val = (wr && a != 5'd0) ? v : 8'h00;
      e.tag = tag;
      sb.push_back(e);
      if (wr && a != 5'd0) m_r[a] = v;
      m_pc = npc;
      @(posedge CLK);
      #1;
      check_out();
   endtask

   task automatic apply_reset(input int edges, input string tag);
      RESET = 1'b0;
      repeat (edges) @(posedge CLK);
      #1;
      RESET = 1'b1;
      for (int i = 0; i < 32; i++) m_r[i] = 8'h00;
      m_pc = 32'd0;
      sb.delete();
      tests++;
      assert (PC === 32'd0) else begin
         fails++;
         $error("FAIL %s_pc got %0h expected 0", tag, PC);
      end
      for (int i = 0; i < 32; i++) chk8($sformatf("%s_r%0d", tag, i), dut.regs[i], 8'h00);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      RESET = 1'b0;
      for (int i = 0; i < 32; i++) imem[i] = enc(4'hC, 5'd0, 5'd0, 5'd0);
      imem[0]  = enc(4'h8, 5'd1, 5'd0, 5'd1);
      imem[1]  = enc(4'h8, 5'd1, 5'd0, 5'd1);
      imem[2]  = enc(4'h8, 5'd2, 5'd0, 5'd2);
      imem[3]  = enc(4'h8, 5'd3, 5'd0, 5'd2);
      imem[4]  = enc(4'h0, 5'd4, 5'd1, 5'd2);
      imem[5]  = enc(4'h1, 5'd5, 5'd4, 5'd5);
      imem[6]  = enc(4'h2, 5'd6, 5'd5, 5'd2);
      imem[7]  = enc(4'h3, 5'd6, 5'd2, 5'd1);
      imem[8]  = enc(4'h4, 5'd7, 5'd3, 5'd5);
      imem[9]  = enc(4'h5, 5'd7, 5'd6, 5'd7);
      imem[10] = enc(4'h6, 5'd8, 5'd7, 5'd0);
      imem[11] = enc(4'h7, 5'd8, 5'd7, 5'd4);
      imem[12] = enc(4'h9, 5'd2, 5'd1, 5'd5);
      imem[13] = enc(4'hB, 5'd0, 5'd0, 5'd12);

      apply_reset(2, "reset");

      for (int i = 0; i < 12; i++) step($sformatf("prog%0d", i));
      chk8("r4_add", dut.regs[4], 8'h03);
      chk8("r5_sub", dut.regs[5], 8'h03);
      chk8("r6_or",  dut.regs[6], 8'h03);
      chk8("r7_nor", dut.regs[7], 8'hFC);
      chk8("r8_srl", dut.regs[8], 8'h1F);

      step("branz_taken");
      tests++;
      assert (PC === 32'd5) else begin
         fails++;
         $error("FAIL branz_target got %0h expected 5", PC);
      end
      for (int i = 5; i < 12; i++) step($sformatf("loop%0d", i));

      imem[12] = enc(4'h9, 5'd1, 5'd1, 5'd5);
      step("branz_equal");
      tests++;
      assert (PC === 32'd13) else begin
         fails++;
         $error("FAIL branz_fallthru got %0h expected d", PC);
      end
      step("jump_back");

      imem[12] = enc(4'hA, 5'd2, 5'd2, 5'd5);
      step("braz_taken");
      for (int i = 5; i < 12; i++) step($sformatf("loop2_%0d", i));

      imem[12] = enc(4'hB, 5'd3, 5'd4, 5'd10);
      step("jump");
      step("jump_t10");
      step("jump_t11");
      imem[12] = {4'hB, 5'bxxxxx, 5'bxxxxx, 5'd10};
      step("jump_x");
      tests++;
      assert (PC === 32'd10) else begin
         fails++;
         $error("FAIL jump_x_target got %0h expected a", PC);
      end
      step("after_x10");

      apply_reset(1, "midreset");
      imem[12] = enc(4'h8, 5'd0, 5'd0, 5'd7);
      imem[13] = enc(4'h0, 5'd9, 5'd0, 5'd0);
      imem[14] = enc(4'hC, 5'd9, 5'd9, 5'd9);
      for (int i = 0; i < 12; i++) step($sformatf("rerun%0d", i));
      chk8("rerun_r8", dut.regs[8], 8'h1F);
      chk8("rerun_r7", dut.regs[7], 8'hFC);
      step("loadi_r0");
      step("add_from_r0");
      chk8("r9_from_r0", dut.regs[9], 8'h00);
      step("nop");
      tests++;
      assert (PC === 32'd15) else begin
         fails++;
         $error("FAIL nop_pc got %0h expected f", PC);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
